// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, in-order imem requests, PC-tagged instruction FIFO
// and valid/ready handoff to decode with execute-driven redirects.
module instruction_fetch_unit #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               busy
);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W:0]   CAP  = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  entry_t           fifo_q [BUF_DEPTH];

  logic             rv, pop, push, issue;
  logic [CNT_W:0]   load;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Responses with nothing in flight are strays from before reset.
  assign rv          = imem_rvalid & (out_q != '0);
  assign instr_valid = (cnt_q != '0) & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign load        = {1'b0, out_q} + {1'b0, cnt_q}
                     - {{CNT_W{1'b0}}, pop};
  assign issue       = (state_q == FETCH) & ~redirect_valid
                     & (load < CAP);
  assign push        = rv & ~redirect_valid & (disc_q == '0);

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign instr_out = fifo_q[rd_q].instr;
  assign instr_pc  = fifo_q[rd_q].pc;
  assign busy      = (state_q != IDLE) | (out_q != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (!fetch_en) state_d = DRAIN;
      DRAIN: begin
        if (fetch_en)         state_d = FETCH;
        else if (out_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    disc_d    = disc_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    out_d     = out_q + CNT_W'(issue) - CNT_W'(rv);
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      disc_d    = out_q - CNT_W'(rv);
      cnt_d     = '0;
      rd_d      = '0;
      wr_d      = '0;
    end else begin
      if (issue) pc_d = pc_q + PC_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + PC_W'(1);
        wr_d      = nxt(wr_q);
      end
      if (rv && disc_q != '0) disc_d = disc_q - CNT_W'(1);
      if (pop) rd_d = nxt(rd_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      if (push) fifo_q[wr_q] <= '{pc: resp_pc_q, instr: imem_rdata};
    end
  end

endmodule
